// File: rtl/e203_exu_fpu_fcmp_pkg.sv
// Shared definitions for the FPU compare/select/classify unit.
// Provides the op codes and the FCLASS one-hot bit positions.
package e203_exu_fpu_fcmp_pkg;

    typedef enum logic [2:0] {
        FcmpOpFeq    = 3'd0,
        FcmpOpFlt    = 3'd1,
        FcmpOpFle    = 3'd2,
        FcmpOpFmin   = 3'd3,
        FcmpOpFmax   = 3'd4,
        FcmpOpFclass = 3'd5
    } fcmp_op_e;

    localparam int unsigned FclsW       = 10;
    localparam int unsigned FclsNegInf  = 0;
    localparam int unsigned FclsNegNorm = 1;
    localparam int unsigned FclsNegSub  = 2;
    localparam int unsigned FclsNegZero = 3;
    localparam int unsigned FclsPosZero = 4;
    localparam int unsigned FclsPosSub  = 5;
    localparam int unsigned FclsPosNorm = 6;
    localparam int unsigned FclsPosInf  = 7;
    localparam int unsigned FclsSnan    = 8;
    localparam int unsigned FclsQnan    = 9;

endpackage

// File: rtl/e203_exu_fpu_fclass.sv
// Combinational IEEE-754 operand classifier: one-hot FCLASS vector plus
// NaN / signalling-NaN / zero flags.
module e203_exu_fpu_fclass
    import e203_exu_fpu_fcmp_pkg::*;
#(
    parameter int unsigned EW = 8,
    parameter int unsigned MW = 23
) (
    input  logic [EW+MW:0]    i_opd,
    output logic [FclsW-1:0]  o_cls,
    output logic              o_is_nan,
    output logic              o_is_snan,
    output logic              o_is_zero
);

    logic          w_sign;
    logic [EW-1:0] w_exp;
    logic [MW-1:0] w_man;
    logic          w_exp_ones;
    logic          w_exp_zero;
    logic          w_man_zero;
    logic          w_inf;
    logic          w_nan;
    logic          w_snan;
    logic          w_zero;
    logic          w_sub;
    logic          w_norm;

    assign w_sign     = i_opd[EW+MW];
    assign w_exp      = i_opd[EW+MW-1:MW];
    assign w_man      = i_opd[MW-1:0];
    assign w_exp_ones = &w_exp;
    assign w_exp_zero = ~|w_exp;
    assign w_man_zero = ~|w_man;

    assign w_inf  = w_exp_ones & w_man_zero;
    assign w_nan  = w_exp_ones & ~w_man_zero;
    // Quiet bit is the fraction MSB; clear means signalling.
    assign w_snan = w_nan & ~w_man[MW-1];
    assign w_zero = w_exp_zero & w_man_zero;
    assign w_sub  = w_exp_zero & ~w_man_zero;
    assign w_norm = ~w_exp_ones & ~w_exp_zero;

    always_comb begin
        o_cls              = '0;
        o_cls[FclsNegInf]  = w_sign & w_inf;
        o_cls[FclsNegNorm] = w_sign & w_norm;
        o_cls[FclsNegSub]  = w_sign & w_sub;
        o_cls[FclsNegZero] = w_sign & w_zero;
        o_cls[FclsPosZero] = ~w_sign & w_zero;
        o_cls[FclsPosSub]  = ~w_sign & w_sub;
        o_cls[FclsPosNorm] = ~w_sign & w_norm;
        o_cls[FclsPosInf]  = ~w_sign & w_inf;
        o_cls[FclsSnan]    = w_snan;
        o_cls[FclsQnan]    = w_nan & ~w_snan;
    end

    assign o_is_nan  = w_nan;
    assign o_is_snan = w_snan;
    assign o_is_zero = w_zero;

endmodule

// File: rtl/e203_exu_fpu_fcmp.sv
// Two-stage pipelined FEQ/FLT/FLE/FMIN/FMAX/FCLASS unit with valid/ready
// back-pressure; S1 holds operands and class flags, S2 holds the result.
module e203_exu_fpu_fcmp
    import e203_exu_fpu_fcmp_pkg::*;
#(
    parameter int unsigned EW   = 8,
    parameter int unsigned MW   = 23,
    parameter int unsigned TAGW = 4,
    localparam int unsigned W   = 1 + EW + MW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            fcmp_i_valid,
    output logic            fcmp_i_ready,
    input  logic [2:0]      fcmp_i_op,
    input  logic [W-1:0]    fcmp_i_rs1,
    input  logic [W-1:0]    fcmp_i_rs2,
    input  logic [TAGW-1:0] fcmp_i_tag,
    output logic            fcmp_o_valid,
    input  logic            fcmp_o_ready,
    output logic [W-1:0]    fcmp_o_wbck_wdat,
    output logic            fcmp_o_nv,
    output logic [TAGW-1:0] fcmp_o_tag
);

    localparam logic [W-1:0] CanonNan = {1'b0, {EW{1'b1}}, 1'b1, {(MW-1){1'b0}}};

    logic [FclsW-1:0] w_cls_a, w_cls_b;
    logic             w_nan_a, w_snan_a, w_zero_a;
    logic             w_nan_b, w_snan_b, w_zero_b;
    logic             w_s1_ld, w_s2_ld, w_accept;

    logic             r_s1_vld;
    logic [2:0]       r_s1_op;
    logic [W-1:0]     r_s1_a, r_s1_b;
    logic [TAGW-1:0]  r_s1_tag;
    logic [FclsW-1:0] r_s1_cls_a;
    logic             r_s1_nan_a, r_s1_snan_a, r_s1_zero_a;
    logic             r_s1_nan_b, r_s1_snan_b, r_s1_zero_b;

    logic             r_s2_vld;
    logic [W-1:0]     r_s2_dat;
    logic             r_s2_nv;
    logic [TAGW-1:0]  r_s2_tag;

    logic [W-1:0]     w_res;
    logic             w_nv;
    logic             unused_cls_b;

    e203_exu_fpu_fclass #(.EW(EW), .MW(MW)) u_fclass_a (
        .i_opd     (fcmp_i_rs1),
        .o_cls     (w_cls_a),
        .o_is_nan  (w_nan_a),
        .o_is_snan (w_snan_a),
        .o_is_zero (w_zero_a)
    );

    e203_exu_fpu_fclass #(.EW(EW), .MW(MW)) u_fclass_b (
        .i_opd     (fcmp_i_rs2),
        .o_cls     (w_cls_b),
        .o_is_nan  (w_nan_b),
        .o_is_snan (w_snan_b),
        .o_is_zero (w_zero_b)
    );

    // rs2 only needs the flags; its one-hot class vector is not consumed.
    assign unused_cls_b = ^w_cls_b;

    assign w_s2_ld      = ~r_s2_vld | fcmp_o_ready;
    assign w_s1_ld      = ~r_s1_vld | w_s2_ld;
    assign fcmp_i_ready = w_s1_ld;
    assign w_accept     = fcmp_i_valid & w_s1_ld;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_vld    <= 1'b0;
            r_s1_op     <= '0;
            r_s1_a      <= '0;
            r_s1_b      <= '0;
            r_s1_tag    <= '0;
            r_s1_cls_a  <= '0;
            r_s1_nan_a  <= 1'b0;
            r_s1_snan_a <= 1'b0;
            r_s1_zero_a <= 1'b0;
            r_s1_nan_b  <= 1'b0;
            r_s1_snan_b <= 1'b0;
            r_s1_zero_b <= 1'b0;
        end else begin
            if (w_s1_ld) begin
                r_s1_vld <= fcmp_i_valid;
            end
            if (w_accept) begin
                r_s1_op     <= fcmp_i_op;
                r_s1_a      <= fcmp_i_rs1;
                r_s1_b      <= fcmp_i_rs2;
                r_s1_tag    <= fcmp_i_tag;
                r_s1_cls_a  <= w_cls_a;
                r_s1_nan_a  <= w_nan_a;
                r_s1_snan_a <= w_snan_a;
                r_s1_zero_a <= w_zero_a;
                r_s1_nan_b  <= w_nan_b;
                r_s1_snan_b <= w_snan_b;
                r_s1_zero_b <= w_zero_b;
            end
        end
    end

    logic w_sa, w_sb, w_any_nan, w_any_snan, w_both_zero;
    logic w_mag_lt, w_mag_gt, w_lt, w_eq, w_a_is_min;

    assign w_sa        = r_s1_a[W-1];
    assign w_sb        = r_s1_b[W-1];
    assign w_any_nan   = r_s1_nan_a | r_s1_nan_b;
    assign w_any_snan  = r_s1_snan_a | r_s1_snan_b;
    assign w_both_zero = r_s1_zero_a & r_s1_zero_b;
    assign w_mag_lt    = r_s1_a[W-2:0] < r_s1_b[W-2:0];
    assign w_mag_gt    = r_s1_a[W-2:0] > r_s1_b[W-2:0];
    assign w_eq        = (r_s1_a == r_s1_b) | w_both_zero;

    always_comb begin
        w_lt = 1'b0;
        if (w_both_zero) begin
            w_lt = 1'b0;
        end else if (w_sa != w_sb) begin
            w_lt = w_sa;
        end else if (w_sa) begin
            w_lt = w_mag_gt;
        end else begin
            w_lt = w_mag_lt;
        end
    end

    // Min/max order -0 below +0, unlike the comparisons.
    assign w_a_is_min = w_both_zero ? (w_sa & ~w_sb) : w_lt;

    always_comb begin
        w_res = '0;
        w_nv  = 1'b0;
        case (r_s1_op)
            FcmpOpFeq: begin
                w_res[0] = ~w_any_nan & w_eq;
                w_nv     = w_any_snan;
            end
            FcmpOpFlt: begin
                w_res[0] = ~w_any_nan & w_lt;
                w_nv     = w_any_nan;
            end
            FcmpOpFle: begin
                w_res[0] = ~w_any_nan & (w_lt | w_eq);
                w_nv     = w_any_nan;
            end
            FcmpOpFmin, FcmpOpFmax: begin
                w_nv = w_any_snan;
                if (r_s1_nan_a & r_s1_nan_b) begin
                    w_res = CanonNan;
                end else if (r_s1_nan_a) begin
                    w_res = r_s1_b;
                end else if (r_s1_nan_b) begin
                    w_res = r_s1_a;
                end else if (r_s1_op == FcmpOpFmin) begin
                    w_res = w_a_is_min ? r_s1_a : r_s1_b;
                end else begin
                    w_res = w_a_is_min ? r_s1_b : r_s1_a;
                end
            end
            FcmpOpFclass: begin
                w_res[FclsW-1:0] = r_s1_cls_a;
            end
            default: begin
                w_res = '0;
                w_nv  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_vld <= 1'b0;
            r_s2_dat <= '0;
            r_s2_nv  <= 1'b0;
            r_s2_tag <= '0;
        end else if (w_s2_ld) begin
            r_s2_vld <= r_s1_vld;
            if (r_s1_vld) begin
                r_s2_dat <= w_res;
                r_s2_nv  <= w_nv;
                r_s2_tag <= r_s1_tag;
            end
        end
    end

    assign fcmp_o_valid     = r_s2_vld;
    assign fcmp_o_wbck_wdat = r_s2_dat;
    assign fcmp_o_nv        = r_s2_nv;
    assign fcmp_o_tag       = r_s2_tag;

endmodule

// File: tb/tb_e203_exu_fpu_fcmp.sv
// Scoreboard bench for e203_exu_fpu_fcmp: directed vectors, streaming,
// stall, reset flush, plus a double-precision build.
module tb_e203_exu_fpu_fcmp;

    logic        clk = 1'b0;
    logic        rst;
    logic        fcmp_i_valid, fcmp_i_ready, fcmp_o_valid, fcmp_o_ready, fcmp_o_nv;
    logic [2:0]  fcmp_i_op;
    logic [31:0] fcmp_i_rs1, fcmp_i_rs2, fcmp_o_wbck_wdat;
    logic [3:0]  fcmp_i_tag, fcmp_o_tag;

    logic        d_i_valid, d_i_ready, d_o_valid, d_o_ready, d_o_nv;
    logic [2:0]  d_i_op;
    logic [63:0] d_i_rs1, d_i_rs2, d_o_wdat;
    logic [3:0]  d_i_tag, d_o_tag;

    always #5 clk = ~clk;

    e203_exu_fpu_fcmp #(.EW(8), .MW(23), .TAGW(4)) u_dut (
        .clk              (clk),
        .rst              (rst),
        .fcmp_i_valid     (fcmp_i_valid),
        .fcmp_i_ready     (fcmp_i_ready),
        .fcmp_i_op        (fcmp_i_op),
        .fcmp_i_rs1       (fcmp_i_rs1),
        .fcmp_i_rs2       (fcmp_i_rs2),
        .fcmp_i_tag       (fcmp_i_tag),
        .fcmp_o_valid     (fcmp_o_valid),
        .fcmp_o_ready     (fcmp_o_ready),
        .fcmp_o_wbck_wdat (fcmp_o_wbck_wdat),
        .fcmp_o_nv        (fcmp_o_nv),
        .fcmp_o_tag       (fcmp_o_tag)
    );

    e203_exu_fpu_fcmp #(.EW(11), .MW(52), .TAGW(4)) u_dut64 (
        .clk              (clk),
        .rst              (rst),
        .fcmp_i_valid     (d_i_valid),
        .fcmp_i_ready     (d_i_ready),
        .fcmp_i_op        (d_i_op),
        .fcmp_i_rs1       (d_i_rs1),
        .fcmp_i_rs2       (d_i_rs2),
        .fcmp_i_tag       (d_i_tag),
        .fcmp_o_valid     (d_o_valid),
        .fcmp_o_ready     (d_o_ready),
        .fcmp_o_wbck_wdat (d_o_wdat),
        .fcmp_o_nv        (d_o_nv),
        .fcmp_o_tag       (d_o_tag)
    );

    typedef struct packed {
        logic [31:0] dat;
        logic        nv;
        logic [3:0]  tag;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    logic [3:0] tag_ctr = 4'd0;

    localparam int NDir = 25;
    logic [2:0]  t_op [NDir] = '{3'd0, 3'd1, 3'd2, 3'd1, 3'd1, 3'd1, 3'd0, 3'd3, 3'd4, 3'd3,
                                 3'd5, 3'd5, 3'd5, 3'd5, 3'd4, 3'd2, 3'd0, 3'd4, 3'd3, 3'd6,
                                 3'd5, 3'd5, 3'd5, 3'd1, 3'd2};
    logic [31:0] t_a [NDir] = '{32'h80000000, 32'h80000000, 32'h80000000, 32'hBF800000,
                                32'hC0000000, 32'h7FC00000, 32'h7FA00000, 32'h7FC00000,
                                32'h7FC00000, 32'h00000000, 32'hFF800000, 32'h00000001,
                                32'h7F800001, 32'h3F800000, 32'h80000000, 32'h3F800000,
                                32'h7FC00000, 32'hBF800000, 32'h7F800001, 32'h3F800000,
                                32'h807FFFFF, 32'h7FC00000, 32'h00000000, 32'h3F800000,
                                32'h40000000};
    logic [31:0] t_b [NDir] = '{32'h00000000, 32'h00000000, 32'h00000000, 32'h3F800000,
                                32'hBF800000, 32'h3F800000, 32'h3F800000, 32'h40400000,
                                32'hFFC00001, 32'h80000000, 32'h0, 32'h0, 32'h0, 32'h0,
                                32'h00000000, 32'h3F800000, 32'h7FC00000, 32'hC0000000,
                                32'h3F800000, 32'h3F800000, 32'h0, 32'h0, 32'h0,
                                32'h40000000, 32'h3F800000};
    logic [31:0] t_e [NDir] = '{32'h1, 32'h0, 32'h1, 32'h1, 32'h1, 32'h0, 32'h0, 32'h40400000,
                                32'h7FC00000, 32'h80000000, 32'h001, 32'h020, 32'h100, 32'h040,
                                32'h00000000, 32'h1, 32'h0, 32'hBF800000, 32'h3F800000, 32'h0,
                                32'h004, 32'h200, 32'h010, 32'h1, 32'h0};
    logic        t_nv [NDir] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0,
                                 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0,
                                 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Present one request from posedge+1 until it is accepted; returns at posedge+1.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] e, input logic env, input bit push);
        logic acc;
        acc          = 1'b0;
        fcmp_i_valid = 1'b1;
        fcmp_i_op    = op;
        fcmp_i_rs1   = a;
        fcmp_i_rs2   = b;
        fcmp_i_tag   = tag_ctr;
        for (int k = 0; k < 200 && !acc; k++) begin
            @(negedge clk);
            acc = fcmp_i_ready;
            @(posedge clk);
            #1;
        end
        if (!acc) begin
            n_checks++;
            $display("FAIL accept_timeout: got no accept expected accept tag %0d", tag_ctr);
        end else if (push) begin
            sb_q.push_back('{dat: e, nv: env, tag: tag_ctr});
        end
        tag_ctr      = tag_ctr + 4'd1;
        fcmp_i_valid = 1'b0;
    endtask

    task automatic run64(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] e, input logic env, input string name);
        logic acc, seen;
        acc       = 1'b0;
        seen      = 1'b0;
        d_i_valid = 1'b1;
        d_i_op    = op;
        d_i_rs1   = a;
        d_i_rs2   = b;
        for (int k = 0; k < 50 && !acc; k++) begin
            @(negedge clk);
            acc = d_i_ready;
            @(posedge clk);
            #1;
        end
        d_i_valid = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(negedge clk);
            if (d_o_valid) begin
                seen = 1'b1;
                chk({name, "_wdat"}, d_o_wdat, e);
                chk({name, "_nv"}, {63'd0, d_o_nv}, {63'd0, env});
            end
        end
        if (!seen) begin
            n_checks++;
            $display("FAIL %s_timeout: got no valid expected valid", name);
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: every retiring beat must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && fcmp_o_valid && fcmp_o_ready) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_out: got tag %0d expected no output", fcmp_o_tag);
            end else begin
                exp_t ex;
                ex = sb_q.pop_front();
                chk($sformatf("wdat_tag%0d", ex.tag), {32'd0, fcmp_o_wbck_wdat},
                    {32'd0, ex.dat});
                chk($sformatf("nv_tag%0d", ex.tag), {63'd0, fcmp_o_nv}, {63'd0, ex.nv});
                chk("tag_order", {60'd0, fcmp_o_tag}, {60'd0, ex.tag});
            end
        end
    end

    task automatic drain();
        for (int k = 0; k < 100 && sb_q.size() != 0; k++) @(posedge clk);
        chk("drained", 64'(sb_q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst          = 1'b1;
        fcmp_i_valid = 1'b0;
        fcmp_i_op    = '0;
        fcmp_i_rs1   = '0;
        fcmp_i_rs2   = '0;
        fcmp_i_tag   = '0;
        fcmp_o_ready = 1'b1;
        d_i_valid    = 1'b0;
        d_i_op       = '0;
        d_i_rs1      = '0;
        d_i_rs2      = '0;
        d_i_tag      = '0;
        d_o_ready    = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        chk("rst_o_valid", {63'd0, fcmp_o_valid}, 64'd0);
        chk("rst_wdat", {32'd0, fcmp_o_wbck_wdat}, 64'd0);
        chk("rst_nv", {63'd0, fcmp_o_nv}, 64'd0);
        chk("rst_tag", {60'd0, fcmp_o_tag}, 64'd0);
        chk("rst_i_ready", {63'd0, fcmp_i_ready}, 64'd1);
        @(posedge clk);
        #1;

        // Single op: visible after the second edge following acceptance.
        issue(3'd1, 32'hBF800000, 32'h3F800000, 32'h1, 1'b0, 1'b1);
        @(negedge clk);
        chk("latency_s1", {63'd0, fcmp_o_valid}, 64'd0);
        @(negedge clk);
        chk("latency_s2", {63'd0, fcmp_o_valid}, 64'd1);
        @(posedge clk);
        #1;

        for (int i = 0; i < NDir; i++) issue(t_op[i], t_a[i], t_b[i], t_e[i], t_nv[i], 1'b1);
        drain();

        // Streaming: FLE(i, 3) on tiny positive subnormals.
        tag_ctr = 4'd0;
        for (int i = 0; i < 8; i++)
            issue(3'd2, 32'(i), 32'd3, (i <= 3) ? 32'd1 : 32'd0, 1'b0, 1'b1);
        drain();

        // Stall: two accepts fill the pipe, third waits until release.
        fcmp_o_ready = 1'b0;
        tag_ctr      = 4'd10;
        issue(3'd0, 32'h3F800000, 32'h3F800000, 32'h1, 1'b0, 1'b1);
        issue(3'd1, 32'h40000000, 32'h3F800000, 32'h0, 1'b0, 1'b1);
        fork
            issue(3'd4, 32'h40000000, 32'hC0000000, 32'h40000000, 1'b0, 1'b1);
            begin
                for (int k = 0; k < 4; k++) begin
                    @(negedge clk);
                    chk("stall_i_ready", {63'd0, fcmp_i_ready}, 64'd0);
                    chk("stall_o_valid", {63'd0, fcmp_o_valid}, 64'd1);
                    chk("stall_wdat", {32'd0, fcmp_o_wbck_wdat}, 64'd1);
                    chk("stall_tag", {60'd0, fcmp_o_tag}, 64'd10);
                end
                @(posedge clk);
                #1 fcmp_o_ready = 1'b1;
            end
        join
        drain();

        // Reset with two ops in flight: they must vanish.
        fcmp_o_ready = 1'b0;
        issue(3'd0, 32'h1, 32'h1, 32'h1, 1'b0, 1'b0);
        issue(3'd0, 32'h2, 32'h2, 32'h1, 1'b0, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("flush_o_valid", {63'd0, fcmp_o_valid}, 64'd0);
        chk("flush_i_ready", {63'd0, fcmp_i_ready}, 64'd1);
        @(posedge clk);
        #1 fcmp_o_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        run64(3'd1, 64'h8000000000000000, 64'h0000000000000000, 64'h0, 1'b0, "dp_flt_zero");
        run64(3'd4, 64'hFFF0000000000001, 64'h7FF8000000000000, 64'h7FF8000000000000, 1'b1,
              "dp_fmax_nan");
        run64(3'd3, 64'h0000000000000000, 64'h8000000000000000, 64'h8000000000000000, 1'b0,
              "dp_fmin_zero");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
